// File: rtl/mux10_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
// Also provides the select-width adequacy check used at elaboration.
package mux_sched_pkg;

    localparam int unsigned N_REQ_DEF    = 10;
    localparam int unsigned SEL_W_DEF    = 4;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_t;

    // True when a select bus of sel_w bits can address every one of n_req inputs.
    function automatic bit sel_w_ok(input int unsigned n_req, input int unsigned sel_w);
        return (64'(1) << sel_w) >= 64'(n_req);
    endfunction

endpackage

// File: rtl/mux10_rr_scheduler_if.sv
// Request/grant bus between the requesters and the mux scheduler.
// The slave modport is the scheduler side; the master modport is the requester side.
interface mux10_rr_scheduler_if
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) ();

    logic             enable;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;

    modport master (
        output enable,
        output req,
        input  grant,
        input  sel,
        input  sel_valid,
        input  busy
    );

    modport slave (
        input  enable,
        input  req,
        output grant,
        output sel,
        output sel_valid,
        output busy
    );

endinterface

// File: rtl/mux10_rr_scheduler_rr_pick.sv
// Combinational rotating-priority encoder: first set request at or after base,
// wrapping at N_REQ-1, optionally skipping one excluded index.
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] base,
    input  logic [SEL_W-1:0] excl,
    input  logic             excl_en,
    output logic             found,
    output logic [SEL_W-1:0] winner
);

    function automatic int unsigned wrap_idx(input int unsigned b, input int unsigned k);
        int unsigned s;
        s = b + k;
        return (s >= N_REQ) ? (s - N_REQ) : s;
    endfunction

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[wrap_idx(32'(base), i)] &&
                !(excl_en && (wrap_idx(32'(base), i) == 32'(excl)))) begin
                found  = 1'b1;
                winner = SEL_W'(wrap_idx(32'(base), i));
            end
        end
    end

endmodule

// File: rtl/mux10_rr_scheduler.sv
// Round-robin owner scheduler for a shared N-input select mux, with a one-cycle
// dead gap on every owner change and a hold limit that forces rotation.
module mux10_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = N_REQ_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    mux10_rr_scheduler_if.slave bus
);

    localparam int unsigned      HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(N_REQ - 1);

    if (!sel_w_ok(N_REQ, SEL_W) || (MAX_HOLD < 1)) begin : g_param_check
        $error("mux10_rr_scheduler: SEL_W too narrow for N_REQ or MAX_HOLD < 1");
    end

    sched_state_t      state;
    sched_state_t      state_next;
    logic [SEL_W-1:0]  last;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0]  base;
    logic              found;
    logic [SEL_W-1:0]  winner;
    logic              load_grant;
    logic              release_owner;

    // Search starts one past the last owner; the owner is searched last, so
    // in GAP it only wins again when nobody else is asking.
    assign base = (last == LAST_IDX) ? '0 : last + 1'b1;

    // While granting, the picker only answers "is anyone else waiting".
    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (bus.req),
        .base    (base),
        .excl    (last),
        .excl_en (state == ST_GRANT),
        .found   (found),
        .winner  (winner)
    );

    assign release_owner = !bus.req[last] || ((hold_cnt == HOLD_LAST) && found);

    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.enable && found) begin
                    state_next = ST_GRANT;
                    load_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_owner) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (bus.enable && found) begin
                    state_next = ST_GRANT;
                    load_grant = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last          <= LAST_IDX;
            hold_cnt      <= '0;
            bus.grant     <= '0;
            bus.sel       <= '0;
            bus.sel_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (load_grant) begin
                bus.grant     <= N_REQ'(1) << winner;
                bus.sel       <= winner;
                bus.sel_valid <= 1'b1;
                last          <= winner;
                hold_cnt      <= '0;
            end else if (state_next != ST_GRANT) begin
                // sel deliberately keeps the previous owner through GAP/IDLE.
                bus.grant     <= '0;
                bus.sel_valid <= 1'b0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux10_rr_scheduler.sv
// Scoreboard bench for mux10_rr_scheduler: a cycle-level reference model pushes
// expected outputs, an independent monitor pops and compares them.
module tb_mux10_rr_scheduler;

    localparam int N    = 10;
    localparam int SW   = 4;
    localparam int HOLD = 8;

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [SW-1:0] sel;
        logic          sel_valid;
        logic          busy;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;

    mux10_rr_scheduler_if #(.N_REQ(N), .SEL_W(SW)) bus ();

    mux10_rr_scheduler #(
        .N_REQ    (N),
        .SEL_W    (SW),
        .MAX_HOLD (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_q[$];
    bit   rst_seen = 1'b0;

    // Reference model state: owner index (-1 = none), gap flag, round-robin
    // pointer, shown selection, and how many cycles the current owner has had.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_last  = N - 1;
    int m_sel   = 0;
    int m_run   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_choose(input logic [N-1:0] r, input int from_last);
        for (int k = 1; k <= N; k++) begin
            if (r[(from_last + k) % N]) return (from_last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit others_waiting(input logic [N-1:0] r, input int who);
        for (int k = 0; k < N; k++) begin
            if (k != who && r[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic e, input logic rn);
        out_t o;
        if (!rn) begin
            m_owner = -1; m_gap = 1'b0; m_last = N - 1; m_sel = 0; m_run = 0;
            rst_seen = 1'b1;
        end else if (m_owner >= 0) begin
            if (!r[m_owner] || (m_run >= HOLD && others_waiting(r, m_owner))) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_run++;
            end
        end else begin
            if (e && r != '0) begin
                m_owner = rr_choose(r, m_last);
                m_last  = m_owner;
                m_sel   = m_owner;
                m_run   = 1;
            end
            m_gap = 1'b0;
        end
        o.grant     = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        o.sel       = SW'(m_sel);
        o.sel_valid = (m_owner >= 0);
        o.busy      = (m_owner >= 0) || m_gap;
        exp_q.push_back(o);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(bus.req, bus.enable, rst_n);
        end
    end

    // Monitor: outputs are presented every cycle once the model has an entry.
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.grant, bus.sel, bus.sel_valid, bus.busy};
                chk("outputs{grant,sel,sel_valid,busy}", 32'(a), 32'(e));
            end
            if (rst_seen) begin
                chk("inv_onehot0", 32'($onehot0(bus.grant)), 32'd1);
                chk("inv_sel_valid", 32'(bus.sel_valid), 32'(|bus.grant));
                if (|bus.grant) chk("inv_grant_at_sel", 32'(bus.grant[bus.sel]), 32'd1);
            end
        end
    end

    task automatic drive(input logic [N-1:0] r, input logic e, input int cycles);
        bus.req    = r;
        bus.enable = e;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, 1'b0, 1);
        rst_n = 1'b1;
    endtask

    task automatic expect_out(input string name, input logic [N-1:0] g, input int s,
                              input logic v, input logic b);
        chk({name, ".grant"}, 32'(bus.grant), 32'(g));
        chk({name, ".sel"}, 32'(bus.sel), 32'(s));
        chk({name, ".sel_valid"}, 32'(bus.sel_valid), 32'(v));
        chk({name, ".busy"}, 32'(bus.busy), 32'(b));
    endtask

    initial begin
        logic [N-1:0] r_rand;
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("reset", '0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single requester: granted after one edge, never rotated.
        drive(10'h004, 1'b1, 1);
        expect_out("single_first", 10'h004, 2, 1'b1, 1'b1);
        drive(10'h004, 1'b1, 12);
        expect_out("single_held", 10'h004, 2, 1'b1, 1'b1);

        // Two contenders: 8-cycle tenures separated by one gap.
        do_reset();
        drive(10'h201, 1'b1, 1);
        expect_out("hold_0_start", 10'h001, 0, 1'b1, 1'b1);
        drive(10'h201, 1'b1, 7);
        expect_out("hold_0_end", 10'h001, 0, 1'b1, 1'b1);
        drive(10'h201, 1'b1, 1);
        expect_out("hold_gap1", '0, 0, 1'b0, 1'b1);
        drive(10'h201, 1'b1, 1);
        expect_out("hold_9_start", 10'h200, 9, 1'b1, 1'b1);
        drive(10'h201, 1'b1, 8);
        expect_out("hold_gap2", '0, 9, 1'b0, 1'b1);
        drive(10'h201, 1'b1, 1);
        expect_out("hold_0_again", 10'h001, 0, 1'b1, 1'b1);

        // Wrap-around from owner 9.
        do_reset();
        drive(10'h200, 1'b1, 3);
        expect_out("wrap_owner9", 10'h200, 9, 1'b1, 1'b1);
        drive(10'h011, 1'b1, 1);
        expect_out("wrap_gap", '0, 9, 1'b0, 1'b1);
        drive(10'h011, 1'b1, 1);
        expect_out("wrap_to_0", 10'h001, 0, 1'b1, 1'b1);
        drive(10'h010, 1'b1, 2);
        expect_out("wrap_to_4", 10'h010, 4, 1'b1, 1'b1);

        // Owner drop with a simultaneous new request.
        do_reset();
        drive(10'h008, 1'b1, 3);
        drive(10'h020, 1'b1, 1);
        expect_out("handover_gap", '0, 3, 1'b0, 1'b1);
        drive(10'h020, 1'b1, 1);
        expect_out("handover_5", 10'h020, 5, 1'b1, 1'b1);

        // enable low blocks new grants.
        do_reset();
        drive(10'h3ff, 1'b0, 4);
        expect_out("disabled_idle", '0, 0, 1'b0, 1'b0);
        drive(10'h3ff, 1'b1, 1);
        expect_out("enabled_grant", 10'h001, 0, 1'b1, 1'b1);

        // Forced rotation with enable low: GAP, then back to IDLE.
        do_reset();
        drive(10'h003, 1'b1, 1);
        drive(10'h003, 1'b0, 7);
        expect_out("en0_hold", 10'h001, 0, 1'b1, 1'b1);
        drive(10'h003, 1'b0, 1);
        expect_out("en0_gap", '0, 0, 1'b0, 1'b1);
        drive(10'h003, 1'b0, 1);
        expect_out("en0_idle", '0, 0, 1'b0, 1'b0);

        // Reset mid-grant: no effect until the edge, reset values after it.
        do_reset();
        drive(10'h040, 1'b1, 3);
        expect_out("pre_reset", 10'h040, 6, 1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        expect_out("reset_no_edge", 10'h040, 6, 1'b1, 1'b1);
        @(negedge clk);
        expect_out("reset_mid_grant", '0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Randomized traffic with sticky requests, occasional disable and reset.
        r_rand = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) r_rand[b] = ~r_rand[b];
            end
            rst_n = ($urandom_range(0, 199) != 0);
            drive(r_rand, ($urandom_range(0, 9) != 0), 1);
        end
        rst_n = 1'b1;
        drive('0, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
